// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: two-master Wishbone round-robin arbiter with a strobe timeout
module wb_rr_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned DW      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic [DW-1:0]   m0_dat_o,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic [31:0]     m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic [DW-1:0]   m1_dat_o,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [31:0]     s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    output logic [1:0]      grant_o
);

    typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic       g0, g1, timeout_hit;

    assign g0          = state_q == GNT0;
    assign g1          = state_q == GNT1;
    assign grant_o     = state_q;
    assign timeout_hit = cnt_q == TO;

    assign s_adr_o  = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
    assign s_dat_o  = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
    assign s_sel_o  = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
    assign s_we_o   = g0 ? m0_we_i  : g1 & m1_we_i;
    assign s_cyc_o  = g0 ? m0_cyc_i : g1 & m1_cyc_i;
    assign s_stb_o  = (g0 ? m0_stb_i : g1 & m1_stb_i) & ~timeout_hit;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // An ack coinciding with the timeout wins, so the error is masked by s_ack_i
    assign m0_ack_o = g0 & s_ack_i & m0_stb_i;
    assign m1_ack_o = g1 & s_ack_i & m1_stb_i;
    assign m0_err_o = g0 & ((s_err_i & m0_stb_i) | (timeout_hit & ~s_ack_i));
    assign m1_err_o = g1 & ((s_err_i & m1_stb_i) | (timeout_hit & ~s_ack_i));

    // Next grant: ties go to the master not served last; the owner keeps the bus until cyc drops
    always_comb begin
        state_d = IDLE;
        unique case (state_q)
            IDLE:    state_d = (m0_cyc_i & m1_cyc_i) ? (last_q ? GNT0 : GNT1) :
                               m0_cyc_i ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
            GNT0:    state_d = m0_cyc_i ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
            GNT1:    state_d = m1_cyc_i ? GNT1 : m0_cyc_i ? GNT0 : IDLE;
            default: state_d = IDLE;
        endcase
        last_d = state_d == GNT0 ? 1'b0 : state_d == GNT1 ? 1'b1 : last_q;
        cnt_d  = (state_q == IDLE || state_d != state_q || s_ack_i || s_err_i || !s_stb_o) ?
                 8'd0 : cnt_q + 8'd1;
    end

    // Grant state, last-served master and timeout counter; reset favours m0 on the first tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed scoreboard bench for the two-master Wishbone arbiter
module tb_wb_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o, m1_adr_i, m1_dat_i, m1_dat_o;
    logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
    logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
    logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
    logic [1:0]  grant_o;

    typedef struct packed {
        logic        a0;
        logic        e0;
        logic        a1;
        logic        e1;
        logic [31:0] dat;
    } rsp_t;

    rsp_t q[$];
    rsp_t exp_r;
    int   checks = 0;
    int   errors = 0;

    wb_rr_arbiter #(.TIMEOUT(8), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
        .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
        .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1);
    end

    // Monitor: every ack/err the DUT presents must match the next queued expectation
    always @(negedge clk) begin
        if (m0_ack_o | m0_err_o | m1_ack_o | m1_err_o) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got a0=%b e0=%b a1=%b e1=%b, required none",
                         m0_ack_o, m0_err_o, m1_ack_o, m1_err_o);
            end else begin
                exp_r = q.pop_front();
                if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} != {exp_r.a0, exp_r.e0, exp_r.a1, exp_r.e1} ||
                    (exp_r.a0 && m0_dat_o != exp_r.dat) || (exp_r.a1 && m1_dat_o != exp_r.dat)) begin
                    errors++;
                    $display("FAIL resp: got a0=%b e0=%b a1=%b e1=%b d0=%h d1=%h, required a0=%b e0=%b a1=%b e1=%b d=%h",
                             m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m0_dat_o, m1_dat_o,
                             exp_r.a0, exp_r.e0, exp_r.a1, exp_r.e1, exp_r.dat);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input logic a0, input logic e0, input logic a1, input logic e1, input logic [31:0] d);
        q.push_back('{a0: a0, e0: e0, a1: a1, e1: e1, dat: d});
    endtask

    initial begin
        rst_n = 1'b0;
        {m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i} = '0;
        {m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i} = '0;
        {s_dat_i, s_ack_i, s_err_i} = '0;
        m0_adr_i = 32'h0000_0100;
        m1_adr_i = 32'h0000_0200;
        m0_sel_i = 4'hF;
        m1_sel_i = 4'h3;
        tick(); tick();
        chk("reset_grant", 32'(grant_o), 32'h0);
        chk("reset_cyc", 32'(s_cyc_o), 32'h0);
        chk("reset_stb", 32'(s_stb_o), 32'h0);
        rst_n = 1'b1;

        // Single m0 read acked after three cycles
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        tick();
        chk("rd_grant", 32'(grant_o), 32'h1);
        chk("rd_cyc", 32'(s_cyc_o), 32'h1);
        chk("rd_adr", s_adr_o, 32'h0000_0100);
        tick(); tick();
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        push(1, 0, 0, 0, 32'hDEAD_BEEF);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        chk("rd_idle", 32'(grant_o), 32'h0);
        chk("idle_adr", s_adr_o, 32'h0);

        // Fresh reset, then simultaneous requests alternate with direct handover
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        chk("tie_grant_m0", 32'(grant_o), 32'h1);
        s_ack_i = 1'b1; s_dat_i = 32'h1111_1111;
        push(1, 0, 0, 0, 32'h1111_1111);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        chk("handover_m1", 32'(grant_o), 32'h2);
        chk("handover_adr", s_adr_o, 32'h0000_0200);
        chk("handover_sel", 32'(s_sel_o), 32'h3);
        s_ack_i = 1'b1; s_dat_i = 32'h2222_2222;
        push(0, 0, 1, 0, 32'h2222_2222);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        chk("handover_m0", 32'(grant_o), 32'h1);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        chk("alt_idle", 32'(grant_o), 32'h0);

        // m1 burst of four words is not preempted by m0
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        chk("burst_grant", 32'(grant_o), 32'h2);
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_ack_i = 1'b1; s_dat_i = 32'hA0 + 32'(i);
            push(0, 0, 1, 0, 32'hA0 + 32'(i));
            tick();
            chk("burst_hold", 32'(grant_o), 32'h2);
        end
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        chk("burst_release", 32'(grant_o), 32'h1);

        // m0 strobe never acked: timeout error eight cycles after grant, then a fresh count
        for (int i = 0; i < 7; i++) tick();
        chk("to_pre_stb", 32'(s_stb_o), 32'h1);
        chk("to_pre_err", 32'(m0_err_o), 32'h0);
        push(0, 1, 0, 0, 32'h0);
        tick();
        chk("to_err", 32'(m0_err_o), 32'h1);
        chk("to_stb_low", 32'(s_stb_o), 32'h0);
        tick();
        chk("to_post_err", 32'(m0_err_o), 32'h0);
        chk("to_post_stb", 32'(s_stb_o), 32'h1);
        for (int i = 0; i < 8; i++) tick();
        chk("to2_stb_low", 32'(s_stb_o), 32'h0);
        s_ack_i = 1'b1; s_dat_i = 32'hCAFE_F00D;
        push(1, 0, 0, 0, 32'hCAFE_F00D);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        chk("to_idle", 32'(grant_o), 32'h0);

        // Reset during an m1 write with m0 waiting; m0 wins after release
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1;
        tick();
        chk("wr_grant", 32'(grant_o), 32'h2);
        chk("wr_we", 32'(s_we_o), 32'h1);
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_cyc", 32'(s_cyc_o), 32'h0);
        s_ack_i = 1'b1;
        #1;
        chk("rst_no_ack", 32'({m0_ack_o, m1_ack_o}), 32'h0);
        tick();
        s_ack_i = 1'b0; rst_n = 1'b1;
        tick();
        chk("rst_m0_first", 32'(grant_o), 32'h1);
        {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, m1_we_i} = '0;
        tick(); tick();

        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
